// File: rtl/nn_pkg.sv
// Shared types and sizing for the batch inference sequencer and its argmax scanner.
package nn_pkg;
  localparam int unsigned IN_WIDTH  = 784;
  localparam int unsigned N_CLASSES = 10;
  localparam int unsigned SCORE_W   = 128;
  localparam int unsigned IDX_W     = 4;

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SCAN,
    EMIT,
    FINISH
  } seq_state_t;
endpackage

// File: rtl/nn_inference_sequencer_argmax_scan.sv
// Sequential argmax: one score per enabled cycle, clear loads the first candidate.
module argmax_scan
  import nn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  score_t           score,
  output logic [IDX_W-1:0] best_idx
);
  score_t           best_score_q, best_score_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;

  // Strict greater-than keeps the earlier index on ties.
  always_comb begin
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    if (en && (clear || (score > best_score_q))) begin
      best_score_d = score;
      best_idx_d   = idx;
    end
  end

  always_ff @(posedge clk) begin
    best_score_q <= best_score_d;
    if (rst) best_idx_q <= '0;
    else     best_idx_q <= best_idx_d;
  end

  assign best_idx = best_idx_q;
endmodule

// File: rtl/nn_inference_sequencer.sv
// Batch inference sequencer: steps image addresses, waits for the network to settle,
// scans the scores for the winner and hands each result out over valid/ready.
module nn_inference_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned NUM_IMAGES    = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  score_t [N_CLASSES-1:0]      scores,
  output logic [31:0]                 addr,
  output logic                        busy,
  output logic [IDX_W-1:0]            class_out,
  output logic [15:0]                 img_idx,
  output logic                        class_valid,
  input  logic                        class_ready,
  output logic                        done
);
  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int SCAN_W = $clog2(N_CLASSES + 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [SCAN_W-1:0] scan_idx_q, scan_idx_d;
  logic [31:0]       addr_q, addr_d;
  logic [15:0]       img_idx_q, img_idx_d;
  logic [IDX_W-1:0]  class_out_q, class_out_d;
  logic              busy_q, busy_d;
  logic              class_valid_q, class_valid_d;
  logic              done_q, done_d;

  score_t            scan_score;
  logic              scan_en;
  logic [IDX_W-1:0]  best_idx;

  always_comb begin
    scan_score = '0;
    for (int k = 0; k < int'(N_CLASSES); k++) begin
      if (scan_idx_q == SCAN_W'(k)) scan_score = scores[k];
    end
  end

  assign scan_en = (state_q == SCAN) && (scan_idx_q < SCAN_W'(N_CLASSES));

  argmax_scan u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clear    (scan_idx_q == '0),
    .en       (scan_en),
    .idx      (IDX_W'(scan_idx_q)),
    .score    (scan_score),
    .best_idx (best_idx)
  );

  // The extra SCAN cycle at idx==N_CLASSES lets the last compare land before class_out latches.
  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    scan_idx_d    = scan_idx_q;
    addr_d        = addr_q;
    img_idx_d     = img_idx_q;
    class_out_d   = class_out_q;
    busy_d        = busy_q;
    class_valid_d = class_valid_q;
    done_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SETTLE;
          addr_d       = '0;
          img_idx_d    = '0;
          settle_cnt_d = '0;
          busy_d       = 1'b1;
        end
      end
      SETTLE: begin
        settle_cnt_d = settle_cnt_q + 1'b1;
        if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d    = SCAN;
          scan_idx_d = '0;
        end
      end
      SCAN: begin
        if (scan_idx_q == SCAN_W'(N_CLASSES)) begin
          state_d       = EMIT;
          class_out_d   = best_idx;
          class_valid_d = 1'b1;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      EMIT: begin
        if (class_valid_q && class_ready) begin
          class_valid_d = 1'b0;
          if (img_idx_q < 16'(NUM_IMAGES - 1)) begin
            addr_d       = addr_q + 32'(IN_WIDTH);
            img_idx_d    = img_idx_q + 16'd1;
            settle_cnt_d = '0;
            state_d      = SETTLE;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      settle_cnt_q  <= '0;
      scan_idx_q    <= '0;
      addr_q        <= '0;
      img_idx_q     <= '0;
      class_out_q   <= '0;
      busy_q        <= 1'b0;
      class_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      scan_idx_q    <= scan_idx_d;
      addr_q        <= addr_d;
      img_idx_q     <= img_idx_d;
      class_out_q   <= class_out_d;
      busy_q        <= busy_d;
      class_valid_q <= class_valid_d;
      done_q        <= done_d;
    end
  end

  assign addr        = addr_q;
  assign busy        = busy_q;
  assign class_out   = class_out_q;
  assign img_idx     = img_idx_q;
  assign class_valid = class_valid_q;
  assign done        = done_q;
endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Directed bench: a single-image instance for the score table, a four-image instance for batches.
module tb_nn_inference_sequencer;
  import nn_pkg::*;

  localparam int SETTLE = 8;
  localparam int LAT    = SETTLE + int'(N_CLASSES) + 1;
  localparam int LIMIT  = 200;

  logic clk = 1'b0;
  logic rst, start, class_ready;
  score_t [N_CLASSES-1:0] scores;

  logic [31:0] addr_a, addr_b;
  logic        busy_a, busy_b, cv_a, cv_b, done_a, done_b;
  logic [3:0]  cls_a, cls_b;
  logic [15:0] img_a, img_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nn_inference_sequencer #(.NUM_IMAGES(1), .SETTLE_CYCLES(SETTLE)) dut_a (
    .clk(clk), .rst(rst), .start(start), .scores(scores), .addr(addr_a), .busy(busy_a),
    .class_out(cls_a), .img_idx(img_a), .class_valid(cv_a), .class_ready(class_ready), .done(done_a));

  nn_inference_sequencer #(.NUM_IMAGES(4), .SETTLE_CYCLES(SETTLE)) dut_b (
    .clk(clk), .rst(rst), .start(start), .scores(scores), .addr(addr_b), .busy(busy_b),
    .class_out(cls_b), .img_idx(img_b), .class_valid(cv_b), .class_ready(class_ready), .done(done_b));

  typedef struct {
    logic [N_CLASSES-1:0][SCORE_W-1:0] sc;
    logic [3:0]                        exp_cls;
  } vec_t;

  vec_t vec [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input bit use_b, input string tag, input bit poke);
    int n = 0;
    while (!(use_b ? cv_b : cv_a) && n < LIMIT) begin
      start = poke && (n == 3);
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(LAT));
  endtask

  task automatic run_vec(input int v);
    scores      = vec[v].sc;
    class_ready = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(1'b0, $sformatf("vec%0d", v), 1'b0);
    check($sformatf("vec%0d class_out", v), 64'(cls_a), 64'(vec[v].exp_cls));
    check($sformatf("vec%0d img_idx", v), 64'(img_a), 64'd0);
    check($sformatf("vec%0d addr", v), 64'(addr_a), 64'd0);
    tick();
    check($sformatf("vec%0d done pulse", v), 64'(done_a), 64'd1);
    check($sformatf("vec%0d valid drop", v), 64'(cv_a), 64'd0);
    check($sformatf("vec%0d busy in finish", v), 64'(busy_a), 64'd1);
    tick();
    check($sformatf("vec%0d done low", v), 64'(done_a), 64'd0);
    check($sformatf("vec%0d busy low", v), 64'(busy_a), 64'd0);
  endtask

  task automatic run_batch(input bit poke);
    string tag;
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    scores      = vec[0].sc;
    class_ready = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int img = 0; img < 4; img++) begin
      tag = $sformatf("batch%0d img%0d", poke, img);
      wait_valid(1'b1, tag, poke);
      check({tag, " addr"}, 64'(addr_b), 64'(img * 784));
      check({tag, " img_idx"}, 64'(img_b), 64'(img));
      check({tag, " class_out"}, 64'(cls_b), 64'd7);
      if (img == 1) begin
        for (int s = 0; s < 5; s++) begin
          start = poke && (s == 2);
          tick();
          check({tag, " stall valid"}, 64'(cv_b), 64'd1);
          check({tag, " stall class"}, 64'(cls_b), 64'd7);
          check({tag, " stall img"}, 64'(img_b), 64'd1);
          check({tag, " stall addr"}, 64'(addr_b), 64'd784);
        end
        start = 1'b0;
      end
      class_ready = 1'b1;
      tick();
      class_ready = 1'b0;
      check({tag, " valid after xfer"}, 64'(cv_b), 64'd0);
      if (img < 3) begin
        check({tag, " no done"}, 64'(done_b), 64'd0);
        check({tag, " busy"}, 64'(busy_b), 64'd1);
        check({tag, " next addr"}, 64'(addr_b), 64'((img + 1) * 784));
      end else begin
        check({tag, " done"}, 64'(done_b), 64'd1);
      end
    end
    tick();
    check($sformatf("batch%0d done once", poke), 64'(done_b), 64'd0);
    check($sformatf("batch%0d idle", poke), 64'(busy_b), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < int'(N_CLASSES); k++) begin
      vec[0].sc[k] = 128'd10;
      vec[1].sc[k] = 128'd0;
      vec[2].sc[k] = 128'd42;
      vec[3].sc[k] = 128'(k);
      vec[4].sc[k] = {SCORE_W{1'b1}} - 128'd1;
      vec[5].sc[k] = 128'(k);
      vec[6].sc[k] = 128'(k);
    end
    vec[0].sc[7] = 128'd500;                vec[0].exp_cls = 4'd7;
    vec[1].sc[2] = 128'd900;
    vec[1].sc[5] = 128'd900;                vec[1].exp_cls = 4'd2;
    vec[2].exp_cls = 4'd0;
    vec[3].sc[9] = 128'd1000;               vec[3].exp_cls = 4'd9;
    vec[4].sc[0] = {SCORE_W{1'b1}};         vec[4].exp_cls = 4'd0;
    vec[5].sc[3] = {1'b1, 127'd0};          vec[5].exp_cls = 4'd3;
    vec[6].sc[4] = 128'd77;
    vec[6].sc[8] = 128'd77;                 vec[6].exp_cls = 4'd4;

    rst         = 1'b1;
    start       = 1'b0;
    class_ready = 1'b0;
    scores      = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle busy_a", 64'(busy_a), 64'd0);
      check("idle busy_b", 64'(busy_b), 64'd0);
      check("idle valid", 64'(cv_b), 64'd0);
      check("idle done", 64'(done_b), 64'd0);
      check("idle addr", 64'(addr_b), 64'd0);
    end
    check("idle class_out", 64'(cls_a), 64'd0);
    check("idle img_idx", 64'(img_a), 64'd0);

    for (int v = 0; v < 7; v++) run_vec(v);

    run_batch(1'b0);
    run_batch(1'b1);

    rst = 1'b1;
    tick();
    rst         = 1'b0;
    scores      = vec[1].sc;
    class_ready = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int img = 0; img < 2; img++) begin
      wait_valid(1'b1, $sformatf("midrst img%0d", img), 1'b0);
      tick();
    end
    for (int c = 0; c < SETTLE + 3; c++) tick();
    check("midrst pre img_idx", 64'(img_b), 64'd2);
    check("midrst pre addr", 64'(addr_b), 64'd1568);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst addr", 64'(addr_b), 64'd0);
    check("midrst valid", 64'(cv_b), 64'd0);
    check("midrst busy", 64'(busy_b), 64'd0);
    check("midrst img_idx", 64'(img_b), 64'd0);
    check("midrst class_out", 64'(cls_b), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(1'b1, "rerun", 1'b0);
    check("rerun addr", 64'(addr_b), 64'd0);
    check("rerun img_idx", 64'(img_b), 64'd0);
    check("rerun class_out", 64'(cls_b), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
